// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of a single spi_core master among REQUESTERS clients.
// Optional watchdog is compiled in by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int          REQUESTERS = 4,
  parameter int          D_WIDTH    = 8,
  parameter int          IDX_W      = 2,
  parameter logic [15:0] TIMEOUT    = 16'd4095
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [REQUESTERS-1:0]         req,
  input  logic [REQUESTERS*D_WIDTH-1:0] req_tx_data,
  input  logic [REQUESTERS-1:0]         req_cpol,
  input  logic [REQUESTERS-1:0]         req_cpha,
  input  logic [REQUESTERS*8-1:0]       req_clk_div,
  output logic [REQUESTERS-1:0]         grant,
  output logic [REQUESTERS-1:0]         done,
  output logic [D_WIDTH-1:0]            rx_data,
  output logic                          error,
  output logic [IDX_W-1:0]              cs_sel,
  output logic                          spi_enable,
  output logic                          spi_cpol,
  output logic                          spi_cpha,
  output logic                          spi_cont,
  output logic [7:0]                    spi_clk_div,
  output logic [D_WIDTH-1:0]            spi_tx_data,
  input  logic                          spi_busy,
  input  logic [D_WIDTH-1:0]            spi_rx_data
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic [1:0]            state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      next_ptr;
  logic [REQUESTERS-1:0] win_onehot;
  logic [D_WIDTH-1:0]    sel_tx;
  logic [7:0]            sel_div;
  logic                  sel_cpol;
  logic                  sel_cpha;
  logic                  arb_go;
  logic                  normal_end;
  logic                  timed_out;
  logic                  txn_end;

  // First set request scanning upward from p, wrapping at REQUESTERS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [REQUESTERS-1:0] r,
                                               input logic [IDX_W-1:0]      p);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               cand;
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < REQUESTERS; off++) begin
      cand = int'(p) + off;
      if (cand >= REQUESTERS) cand = cand - REQUESTERS;
      if (!found && ((r >> cand) & REQUESTERS'(1)) != '0) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
    return pick;
  endfunction

  always_comb begin
    win_idx    = rr_pick(req, ptr);
    win_onehot = REQUESTERS'(1) << win_idx;
    sel_tx     = D_WIDTH'(req_tx_data >> (int'(win_idx) * D_WIDTH));
    sel_div    = 8'(req_clk_div >> (int'(win_idx) * 8));
    sel_cpol   = |(req_cpol & win_onehot);
    sel_cpha   = |(req_cpha & win_onehot);
  end

  // Holding off while busy also covers the core's busy period out of reset.
  assign arb_go     = (state == ST_IDLE) && !spi_busy && (|req);
  assign normal_end = (state == ST_WAIT_DONE) && !spi_busy;
  assign txn_end    = normal_end || timed_out;
  assign next_ptr   = (cs_sel == IDX_W'(REQUESTERS - 1)) ? '0 : cs_sel + 1'b1;
  assign spi_cont   = 1'b0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant       <= '0;
      done        <= '0;
      rx_data     <= '0;
      cs_sel      <= '0;
      spi_enable  <= 1'b0;
      spi_cpol    <= 1'b0;
      spi_cpha    <= 1'b0;
      spi_clk_div <= '0;
      spi_tx_data <= '0;
    end else begin
      done       <= '0;
      spi_enable <= 1'b0;
      if (arb_go) begin
        grant       <= win_onehot;
        cs_sel      <= win_idx;
        spi_tx_data <= sel_tx;
        spi_cpol    <= sel_cpol;
        spi_cpha    <= sel_cpha;
        spi_clk_div <= sel_div;
        spi_enable  <= 1'b1;
        state       <= ST_WAIT_BUSY;
      end else if (txn_end) begin
        // The owner's done bit is simply its grant bit; ptr moves past the owner.
        if (normal_end) rx_data <= spi_rx_data;
        done  <= grant;
        grant <= '0;
        ptr   <= next_ptr;
        state <= ST_IDLE;
      end else if (state == ST_WAIT_BUSY && spi_busy) begin
        state <= ST_WAIT_DONE;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] wdog;

  assign timed_out = (state != ST_IDLE) && (wdog == TIMEOUT - 16'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog  <= '0;
      error <= 1'b0;
    end else begin
      // A completion on the same edge as the limit counts as a normal finish.
      error <= timed_out && !normal_end;
      if (arb_go)
        wdog <= '0;
      else if (state != ST_IDLE)
        wdog <= wdog + 16'd1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign error     = 1'b0;

  // TIMEOUT only sizes the watchdog; referenced here so this build still elaborates it.
  if (TIMEOUT == 16'd0) begin : g_watchdog_limit_unused
  end
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: directed scenarios plus randomized client traffic, all outputs
// compared every cycle against a transaction-level reference model and a simple core model.
`timescale 1ns/1ps
module tb_spi_arbiter;
  localparam int          R  = 4;
  localparam int          DW = 8;
  localparam logic [15:0] TO = 16'd100;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [R-1:0]    req;
  logic [R*DW-1:0] req_tx_data;
  logic [R-1:0]    req_cpol, req_cpha;
  logic [R*8-1:0]  req_clk_div;
  logic [R-1:0]    grant, done;
  logic [DW-1:0]   rx_data;
  logic            error;
  logic [1:0]      cs_sel;
  logic            spi_enable, spi_cpol, spi_cpha, spi_cont;
  logic [7:0]      spi_clk_div;
  logic [DW-1:0]   spi_tx_data;
  logic            spi_busy;
  logic [DW-1:0]   spi_rx_data;

  int n_checks = 0;
  int n_fail   = 0;

  spi_arbiter #(.REQUESTERS(R), .D_WIDTH(DW), .IDX_W(2), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_tx_data(req_tx_data),
    .req_cpol(req_cpol), .req_cpha(req_cpha), .req_clk_div(req_clk_div),
    .grant(grant), .done(done), .rx_data(rx_data), .error(error), .cs_sel(cs_sel),
    .spi_enable(spi_enable), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha), .spi_cont(spi_cont),
    .spi_clk_div(spi_clk_div), .spi_tx_data(spi_tx_data), .spi_busy(spi_busy),
    .spi_rx_data(spi_rx_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Core model: busy for 5 cycles out of reset, raises busy one edge after enable,
  // stays busy core_len+1 cycles, returns tx ^ 8'h99 as the received word.
  int         boot, core_cnt;
  int         core_len = 2;
  logic       core_stuck = 1'b0;
  logic [7:0] core_tx;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      spi_busy <= 1'b1; boot <= 5; core_cnt <= 0; spi_rx_data <= '0; core_tx <= '0;
    end else if (boot != 0) begin
      boot <= boot - 1;
      if (boot == 1) spi_busy <= 1'b0;
    end else if (!spi_busy) begin
      if (spi_enable && !core_stuck) begin
        spi_busy <= 1'b1; core_cnt <= core_len; core_tx <= spi_tx_data;
      end
    end else if (core_cnt == 0) begin
      spi_busy <= 1'b0; spi_rx_data <= core_tx ^ 8'h99;
    end else begin
      core_cnt <= core_cnt - 1;
    end
  end

  // Reference model state: who owns the core, what each output should hold.
  int         m_owner, m_ptr, m_win, m_age, m_cs;
  bit         m_pred, m_pend, m_pend_err;
  logic [7:0] m_tx, m_div, m_exp_rx, m_last_rx;
  logic       m_cpol, m_cpha, prev_busy;
  logic [R-1:0] exp_g;
  int         grant_log[$];
  int         done_cnt[R];
  int         done_total = 0;
  int         err_total  = 0;

  function automatic int rr_model(input logic [R-1:0] r, input int p);
    for (int k = 0; k < R; k++) if (r[(p + k) % R]) return (p + k) % R;
    return 0;
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_cs = 0; m_pred = 0; m_pend = 0; m_pend_err = 0; prev_busy = 1'b1;
      m_tx = '0; m_div = '0; m_cpol = 1'b0; m_cpha = 1'b0; m_last_rx = '0; m_age = 0;
    end else begin
      if (m_pred) begin
        chk("grant_onehot", grant, R'(1) << m_win);
        chk("enable_pulse", spi_enable, 1);
        chk("done_at_grant", done, 0);
        m_owner = m_win; m_cs = m_win; m_age = 0; m_exp_rx = m_tx ^ 8'h99;
        grant_log.push_back(m_win);
      end else if (m_pend) begin
        chk("done_owner", done, R'(1) << m_owner);
        chk("grant_clear", grant, 0);
        chk("error_flag", error, m_pend_err);
        if (!m_pend_err) m_last_rx = m_exp_rx;
        chk("rx_at_done", rx_data, m_last_rx);
        done_cnt[m_owner]++; done_total++;
        if (error) err_total++;
        m_ptr = (m_owner + 1) % R; m_owner = -1;
      end else begin
        if (m_owner >= 0) m_age++;
        exp_g = (m_owner >= 0) ? (R'(1) << m_owner) : '0;
        chk("grant_hold", grant, exp_g);
        chk("done_quiet", done, 0);
        chk("enable_quiet", spi_enable, 0);
        chk("error_quiet", error, 0);
        chk("rx_hold", rx_data, m_last_rx);
      end
      chk("cs_sel", cs_sel, m_cs);
      chk("spi_tx_data", spi_tx_data, m_tx);
      chk("spi_mode", {spi_cont, spi_cpol, spi_cpha}, {1'b0, m_cpol, m_cpha});
      chk("spi_clk_div", spi_clk_div, m_div);
      // Predict what the next edge must do.
      m_pred = 0; m_pend = 0; m_pend_err = 0;
      if (m_owner >= 0) begin
        if (prev_busy && !spi_busy) m_pend = 1;
`ifdef SPI_ARB_TIMEOUT_EN
        else if (m_age == int'(TO) - 1) begin m_pend = 1; m_pend_err = 1; end
`endif
      end else if (!spi_busy && req != '0) begin
        m_pred = 1;
        m_win  = rr_model(req, m_ptr);
        m_tx   = req_tx_data[m_win*DW +: DW];
        m_div  = req_clk_div[m_win*8 +: 8];
        m_cpol = req_cpol[m_win];
        m_cpha = req_cpha[m_win];
      end
      prev_busy = spi_busy;
    end
  end

  logic [R-1:0] keep = '0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      for (int i = 0; i < R; i++) if (done[i] && !keep[i]) req[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0; req = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    step(6);
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int c = 0;
    while (done_total < target && c < budget) begin step(1); c++; end
    chk(tag, done_total >= target, 1);
  endtask

  task automatic wait_grant(input string tag, input int i, input int budget);
    int c = 0;
    while (!grant[i] && c < budget) begin step(1); c++; end
    chk(tag, grant[i], 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {grant, done, error, cs_sel, spi_enable, spi_cpol, spi_cpha, spi_cont}, 0);
    chk({tag, "_data"}, {rx_data, spi_tx_data, spi_clk_div}, 0);
  endtask

  initial begin
    int base, cnt0;
    int snap[R];
    reset_n = 1'b0; req = '0; req_tx_data = '0; req_cpol = '0; req_cpha = '0; req_clk_div = '0;
    req[0] = 1'b1; req_tx_data[7:0] = 8'hA5;
    @(posedge clock); #1;
    chk_all_zero("reset_outputs");
    @(posedge clock); #1 reset_n = 1'b1;
    step(3);
    chk("no_grant_while_busy", grant, 0);
    wait_grant("t1_grant", 0, 20);
    chk("t1_tx", spi_tx_data, 8'hA5);
    wait_done("t1_done", 1, 30);
    chk("t1_rx", rx_data, 8'h3C);

    // Two simultaneous requests with ptr at 0.
    do_reset();
    grant_log.delete(); base = done_total;
    req_tx_data = {8'h13, 8'h22, 8'h31, 8'h40};
    req = 4'b1010;
    wait_done("t2_done", base + 2, 60);
    chk("t2_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("t2_first", grant_log[0], 1);
      chk("t2_second", grant_log[1], 3);
    end

    // All four continuously requesting.
    do_reset();
    grant_log.delete(); base = done_total;
    for (int i = 0; i < R; i++) done_cnt[i] = 0;
    keep = '1; req = '1;
    wait_done("t3_done", base + 8, 200);
    for (int i = 0; i < R; i++) snap[i] = done_cnt[i];
    keep = '0; req = '0;
    chk("t3_count", grant_log.size() >= 8, 1);
    if (grant_log.size() >= 8)
      for (int i = 0; i < 8; i++) chk("t3_order", grant_log[i], i % R);
    for (int i = 0; i < R; i++) chk("t3_done_twice", snap[i], 2);
    step(30);

    // Per-client mode.
    base = done_total;
    req_cpol[2] = 1'b1; req_cpha[2] = 1'b1; req_clk_div[23:16] = 8'd4; req_tx_data[23:16] = 8'h6E;
    req[2] = 1'b1;
    wait_grant("t4_grant", 2, 20);
    step(1);
    chk("t4_cpol", spi_cpol, 1);
    chk("t4_cpha", spi_cpha, 1);
    chk("t4_div", spi_clk_div, 4);
    chk("t4_cont", spi_cont, 0);
    wait_done("t4_done", base + 1, 40);

    // Request dropped right after grant still completes.
    base = done_total; cnt0 = done_cnt[0];
    req_tx_data[7:0] = 8'hC3; req[0] = 1'b1;
    wait_grant("t5_grant", 0, 20);
    step(1); req[0] = 1'b0;
    wait_done("t5_done", base + 1, 40);
    chk("t5_done0", done_cnt[0], cnt0 + 1);

    // Reset in the middle of WAIT_DONE.
    core_len = 6; req_tx_data[31:24] = 8'h5A; req[3] = 1'b1;
    wait_grant("t6_grant", 3, 20);
    step(3);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("t6_async_reset");
    base = done_total;
    for (int i = 0; i < 3; i++) begin step(1); chk("t6_no_done", done, 0); end
    req = '0; reset_n = 1'b1;
    step(10);
    chk("t6_no_done_total", done_total, base);

    // Randomized client traffic.
    base = done_total;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step(1);
      core_len = $urandom_range(0, 5);
      for (int i = 0; i < R; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            req_tx_data[i*DW +: DW] = 8'($urandom);
            req_clk_div[i*8 +: 8] = 8'($urandom);
            req_cpol[i] = 1'($urandom); req_cpha[i] = 1'($urandom);
            keep[i] = ($urandom_range(0, 3) == 0);
          end
        end else if (!grant[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
          else if ($urandom_range(0, 7) == 0) req_tx_data[i*DW +: DW] = 8'($urandom);
        end
      end
    end
    keep = '0; req = '0;
    step(30);
    chk("rand_activity", done_total > base + 50, 1);

`ifdef SPI_ARB_TIMEOUT_EN
    // Core never raises busy: watchdog ends the transaction.
    base = done_total; cnt0 = err_total;
    core_stuck = 1'b1; req_tx_data[7:0] = 8'h77; req[0] = 1'b1;
    wait_done("to_done", base + 1, 300);
    chk("to_error", err_total, cnt0 + 1);
    core_stuck = 1'b0; req = '0;
    step(10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed running required finished");
    $fatal(1);
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and sequencer that shares one `spi_core` master among up to `REQUESTERS` independent clients. It owns the core's command-side inputs and starts each single-word transaction with a one-cycle enable pulse. It tracks the core's `busy` handshake, returns the received word and a completion pulse to the winning client, and exports the winner index for the external slave-select decode.

## Interface
- `REQUESTERS`, 4: number of clients, range 2–16.
- `D_WIDTH`, 8: SPI word width; must equal the core's `D_WIDTH`.
- `IDX_W`, 2: width of `cs_sel`; must satisfy 2^IDX_W >= REQUESTERS.
- `TIMEOUT`, 16'd4095: watchdog limit in clock cycles; used only when `SPI_ARB_TIMEOUT_EN` is defined.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  REQUESTERS  per-client transaction request, level.
- `req_tx_data`  in  REQUESTERS*D_WIDTH  per-client TX word; client i in slice [i*D_WIDTH +: D_WIDTH].
- `req_cpol`, `req_cpha`  in  REQUESTERS each  per-client SPI mode.
- `req_clk_div`  in  REQUESTERS*8  per-client clock divider; client i in [i*8 +: 8].
- `grant`  out  REQUESTERS  one-hot owner, held for the whole transaction.
- `done`  out  REQUESTERS  one-cycle completion pulse to the owner.
- `rx_data`  out  D_WIDTH  last received word; valid in the `done` cycle and held afterwards.
- `error`  out  1  one-cycle timeout pulse, coincident with `done`.
- `cs_sel`  out  IDX_W  binary index of the current or last owner.
- `spi_enable`  out  1  core start pulse.
- `spi_cpol`, `spi_cpha`, `spi_cont`  out  1 each  core mode inputs; `spi_cont` is tied 0.
- `spi_clk_div`  out  8  core divider.
- `spi_tx_data`  out  D_WIDTH  core TX word.
- `spi_busy`  in  1  core busy.
- `spi_rx_data`  in  D_WIDTH  core RX word.

## Operation
- Reset values: all outputs are 0 (`grant`, `done`, `error`, `rx_data`, `cs_sel`, `spi_*`). The round-robin pointer `ptr` is 0 and the state is IDLE.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitrates only when `spi_busy==0` and `|req`. This covers the core's post-reset `busy=1` period.
  - The winner is the first set `req` bit scanning `ptr`, `ptr+1`, … modulo REQUESTERS.
  - On the winning edge, the block:
    - sets `grant` one-hot and `cs_sel` to the winner index;
    - latches the winner's `tx_data`, `cpol`, `cpha` and `clk_div` onto the `spi_*` outputs;
    - sets `spi_enable=1`;
    - moves to WAIT_BUSY.
- WAIT_BUSY:
  - `spi_enable` returns to 0 on the first edge; it is exactly one cycle wide.
  - When `spi_busy==1`, the state moves to WAIT_DONE.
- WAIT_DONE:
  - When `spi_busy==0`, the block:
    - sets `rx_data<=spi_rx_data`;
    - sets the winner's `done` bit to 1 for one cycle;
    - clears `grant`;
    - sets `ptr<=(winner+1) mod REQUESTERS`;
    - returns to IDLE.
- `spi_*` configuration outputs hold their latched values until the next grant; clients may change their inputs after the grant edge.
- Client rules:
  - A client holds `req` until it sees `done`.
  - Deasserting `req` before grant withdraws the request.
  - Deasserting `req` after grant has no effect; the transaction completes and `done` still pulses.
- A client that holds `req` high through its `done` cycle is eligible again, but it ranks last behind every other pending client.
- `reset_n` low at any time returns every output and `ptr` to its reset value immediately. The current transaction is abandoned without `done`.

## Timing
- Request visible at edge k with IDLE and `busy=0`: `grant` and `spi_enable` are high after edge k.
- The core samples enable at edge k+1 and raises `busy`.
- The arbiter detects `busy` at edge k+2 and enters WAIT_DONE.
- The core drops `busy` and updates `rx_data` on the same edge. `done` and `rx_data` follow one edge later.
- Back-to-back: the next grant occurs one edge after `done`, provided `busy==0`.
- Minimum gap between two transactions is 2 cycles; the arbitration overhead is 3 cycles.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A 16-bit watchdog clears on grant and counts every cycle in WAIT_BUSY and WAIT_DONE.
  - Reaching `TIMEOUT` produces `error=1` and the owner's `done=1` for one cycle, clears `grant`, advances `ptr`, and returns to IDLE.
  - `rx_data` is unchanged on a timeout.
  - IDLE still waits for `spi_busy==0` before the next grant.
- Undefined: no watchdog logic exists, `error` is tied 0, and WAIT_BUSY/WAIT_DONE wait indefinitely.

## Test plan
- Reset, with `spi_busy` held at 1 for 5 cycles and `req=4'b0001`: there is no grant until `busy` falls. Then `grant=0001`, one enable pulse, `spi_tx_data=8'hA5`, and `done[0]` arrives with `rx_data=8'h3C` looped back from the core model.
- `req=4'b1010` simultaneously with `ptr=0`: client 1 is served first, then client 3. `cs_sel` shows 1 then 3, with `done[1]` before `done[3]`.
- All four requests held continuously for 8 transactions: the grant order is 0,1,2,3,0,1,2,3, and each `done` bit pulses exactly twice.
- Per-client mode: client 2 has `cpol=1`, `cpha=1` and `clk_div=4`. During its transaction `spi_cpol=1`, `spi_cpha=1` and `spi_clk_div=4`, while `spi_cont` stays 0 throughout.
- Client 0 drops `req` one cycle after grant: the transaction completes and `done[0]` pulses. `reset_n` pulsed low mid-WAIT_DONE: all outputs are 0 immediately, with no `done`.
- With `SPI_ARB_TIMEOUT_EN` and `TIMEOUT=100`, `spi_busy` never rises: after 100 cycles in WAIT_BUSY, `error` and `done[owner]` pulse together, `rx_data` is unchanged, and `grant` clears.
